// File: rtl/config_chain_loader_if.sv
// config_chain_loader_if: host word handshake, serial chain port and load status of config_chain_loader
interface config_chain_loader_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 7
);
    logic              start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              chain_config_in;
    logic              chain_config_en;
    logic              chain_config_out;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  bit_count;

    modport master (
        output start, cfg_data, cfg_valid, chain_config_out,
        input  cfg_ready, chain_config_in, chain_config_en, busy, done, error, bit_count
    );

    modport slave (
        input  start, cfg_data, cfg_valid, chain_config_out,
        output cfg_ready, chain_config_in, chain_config_en, busy, done, error, bit_count
    );
endinterface

// File: rtl/config_chain_loader.sv
// config_chain_loader: shifts host config words LSB-first into a tile config chain; CONFIG_CRC_EN adds a trailing CRC-8 check
module config_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input logic                  config_clk,
    input logic                  reset,
    config_chain_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_WORD, SHIFT, DONE, CRC_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              last_bit;
    int                left;
    logic              unused_chain_out;
`ifdef CONFIG_CRC_EN
    logic [7:0]        crc_q, crc_d;
    logic              error_q, error_d;
`endif

    assign unused_chain_out = bus.chain_config_out;

    // next-state, word latch, per-bit shift and saturating bit counter
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_count_d = bit_count_q;
        rem_d       = rem_q;
        left        = CHAIN_LEN - int'(bit_count_q);
        last_bit    = bit_count_q == CNT_W'(CHAIN_LEN - 1);
`ifdef CONFIG_CRC_EN
        crc_d       = crc_q;
        error_d     = error_q;
`endif
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d     = WAIT_WORD;
                bit_count_d = '0;
`ifdef CONFIG_CRC_EN
                crc_d       = '0;
                error_d     = 1'b0;
`endif
            end
            WAIT_WORD: if (bus.cfg_valid) begin
                state_d = SHIFT;
                shreg_d = bus.cfg_data;
                rem_d   = CNT_W'((left < WORD_W) ? left : WORD_W);
            end
            SHIFT: begin
                shreg_d     = shreg_q >> 1;
                bit_count_d = (bit_count_q == CNT_W'(CHAIN_LEN)) ? bit_count_q : bit_count_q + 1'b1;
                rem_d       = rem_q - 1'b1;
`ifdef CONFIG_CRC_EN
                crc_d       = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ shreg_q[0]) ? 8'h07 : 8'h00);
                state_d     = last_bit ? CRC_WAIT : (rem_q == CNT_W'(1)) ? WAIT_WORD : SHIFT;
`else
                state_d     = last_bit ? DONE : (rem_q == CNT_W'(1)) ? WAIT_WORD : SHIFT;
`endif
            end
`ifdef CONFIG_CRC_EN
            CRC_WAIT: if (bus.cfg_valid) begin
                error_d = bus.cfg_data[7:0] != crc_q;
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any load in progress
    always_ff @(posedge config_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_count_q <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_count_q <= bit_count_d;
            rem_q       <= rem_d;
        end
    end

`ifdef CONFIG_CRC_EN
    // running CRC of shifted bits and the trailing-word comparison result
    always_ff @(posedge config_clk) begin
        if (reset) begin
            crc_q   <= '0;
            error_q <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            error_q <= error_d;
        end
    end
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.cfg_ready       = state_q == WAIT_WORD || state_q == CRC_WAIT;
    assign bus.chain_config_en = state_q == SHIFT;
    assign bus.chain_config_in = bus.chain_config_en & shreg_q[0];
    assign bus.busy            = !(state_q == IDLE || state_q == DONE);
    assign bus.done            = state_q == DONE;
    assign bus.bit_count       = bit_count_q;
endmodule
